uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter.
// Frame = start bit, DATA_W data bits LSB first, optional parity bit,
// STOP_BITS stop bits, then a one-cycle DONE pulse before returning to IDLE.
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state and
// even/odd parity generation; without it Parity_Mode is accepted but ignored.
module uart_tx_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              Tx_Valid,
   input  logic [DATA_W-1:0] Tx_Data,
   input  logic [1:0]        Parity_Mode,
   output logic              Tx_Ready,
   output logic              Tx_Busy,
   output logic              Tx_Done_Sig,
   output logic              Tx_Pin_Out
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

   state_t              state_reg;
   logic [CNT_W-1:0]    clk_cnt_reg;
   // Shared index: data bit position in DATA, stop bit number in STOP.
   logic [IDX_W-1:0]    bit_idx_reg;
   logic [DATA_W-1:0]   shift_reg;
   logic                bit_end;

`ifdef UART_TX_PARITY_EN
   logic                parity_bit_reg;
   logic                parity_en_reg;
`else
   // Parity_Mode stays on the port for drop-in compatibility but is not used.
   logic                unused_parity_mode;
   assign unused_parity_mode = ^Parity_Mode;
`endif

   // Last cycle of the current bit period.
   assign bit_end = (clk_cnt_reg == CNT_LAST);

   // Transmit FSM with registered line, handshake and status outputs.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_reg      <= IDLE;
         clk_cnt_reg    <= '0;
         bit_idx_reg    <= '0;
         shift_reg      <= '0;
         Tx_Ready       <= 1'b0;
         Tx_Busy        <= 1'b0;
         Tx_Done_Sig    <= 1'b0;
         Tx_Pin_Out     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit_reg <= 1'b0;
         parity_en_reg  <= 1'b0;
`endif
      end else begin
         // Bit timer runs only while a frame is on the line (Tx_Busy).
         if (Tx_Busy) begin
            clk_cnt_reg <= bit_end ? '0 : clk_cnt_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (Tx_Valid && Tx_Ready) begin
                  state_reg      <= START;
                  shift_reg      <= Tx_Data;
                  clk_cnt_reg    <= '0;
                  bit_idx_reg    <= '0;
                  Tx_Ready       <= 1'b0;
                  Tx_Busy        <= 1'b1;
                  Tx_Pin_Out     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  parity_en_reg  <= Parity_Mode[0] ^ Parity_Mode[1];
                  parity_bit_reg <= (^Tx_Data) ^ (Parity_Mode == 2'b10);
`endif
               end else begin
                  Tx_Ready <= 1'b1;
               end
            end

            START: begin
               if (bit_end) begin
                  state_reg  <= DATA;
                  Tx_Pin_Out <= shift_reg[0];
                  shift_reg  <= shift_reg >> 1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  if (bit_idx_reg == DATA_LAST) begin
                     bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
                     if (parity_en_reg) begin
                        state_reg  <= PARITY;
                        Tx_Pin_Out <= parity_bit_reg;
                     end else begin
                        state_reg  <= STOP;
                        Tx_Pin_Out <= 1'b1;
                     end
`else
                     state_reg  <= STOP;
                     Tx_Pin_Out <= 1'b1;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                     Tx_Pin_Out  <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state_reg  <= STOP;
                  Tx_Pin_Out <= 1'b1;
               end
            end
`endif

            STOP: begin
               if (bit_end) begin
                  if (bit_idx_reg == STOP_LAST) begin
                     state_reg   <= DONE;
                     bit_idx_reg <= '0;
                     Tx_Busy     <= 1'b0;
                     Tx_Done_Sig <= 1'b1;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end
            end

            DONE: begin
               state_reg   <= IDLE;
               Tx_Done_Sig <= 1'b0;
               Tx_Ready    <= 1'b1;
            end

            default: begin
               state_reg   <= IDLE;
               Tx_Busy     <= 1'b0;
               Tx_Done_Sig <= 1'b0;
               Tx_Pin_Out  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed, table-driven bench for uart_tx_param.
// Main instance: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1.
// Second instance: DATA_W=5, CLKS_PER_BIT=4, STOP_BITS=2.
module tb_uart_tx_param;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       CLK;
   logic       RST_n;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] parity_mode;
   logic       tx_ready, tx_busy, tx_done, tx_pin;

   logic       v2;
   logic [4:0] d2;
   logic [1:0] m2;
   logic       rdy2, busy2, done2, pin2;

   int checks;
   int errors;

   typedef struct {
      string      name;
      logic [7:0] data;
      logic [1:0] mode;
      int         slots;
      logic [15:0] bits;   // expected line value per bit slot, slot 0 = start
   } vec_t;

   vec_t vecs [5];

   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .CLK         (CLK),
      .RST_n       (RST_n),
      .Tx_Valid    (tx_valid),
      .Tx_Data     (tx_data),
      .Parity_Mode (parity_mode),
      .Tx_Ready    (tx_ready),
      .Tx_Busy     (tx_busy),
      .Tx_Done_Sig (tx_done),
      .Tx_Pin_Out  (tx_pin)
   );

   uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .CLK         (CLK),
      .RST_n       (RST_n),
      .Tx_Valid    (v2),
      .Tx_Data     (d2),
      .Parity_Mode (m2),
      .Tx_Ready    (rdy2),
      .Tx_Busy     (busy2),
      .Tx_Done_Sig (done2),
      .Tx_Pin_Out  (pin2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bounded wait (at negedges) for the main instance to be ready.
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (tx_ready !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk({name, "_ready_wait"}, tx_ready, 1'b1);
   endtask

   // Called at the negedge of line cycle 1 (first cycle after acceptance).
   // Samples the whole frame, then checks the DONE cycle and the IDLE cycle.
   // Returns at the negedge of cycle line+2.
   task automatic check_frame(input string name, input logic [15:0] bits, input int slots,
                              input int chg_cycle, input logic [7:0] new_data,
                              input logic new_valid, input logic [1:0] new_mode);
      int          line;
      int          s;
      logic [15:0] seen;
      logic        done_or, busy_and, ready_or;
      line     = slots * CPB;
      seen     = '0;
      done_or  = 1'b0;
      busy_and = 1'b1;
      ready_or = 1'b0;
      for (int c = 1; c <= line; c++) begin
         if (c > 1) @(negedge CLK);
         if (c == chg_cycle) begin
            tx_data     = new_data;
            tx_valid    = new_valid;
            parity_mode = new_mode;
         end
         s = (c - 1) / CPB;
         if (((c - 1) % CPB) == 0 || tx_pin !== bits[s]) seen[s] = tx_pin;
         done_or  = done_or | tx_done;
         busy_and = busy_and & tx_busy;
         ready_or = ready_or | tx_ready;
      end
      for (int k = 0; k < slots; k++)
         chk($sformatf("%s_slot%0d", name, k), seen[k], bits[k]);
      chk({name, "_done_early"}, done_or, 1'b0);
      chk({name, "_busy_line"}, busy_and, 1'b1);
      chk({name, "_ready_line"}, ready_or, 1'b0);
      @(negedge CLK);
      chk({name, "_done_pulse"}, tx_done, 1'b1);
      chk({name, "_done_pin"}, tx_pin, 1'b1);
      chk({name, "_done_busy"}, tx_busy, 1'b0);
      chk({name, "_done_ready"}, tx_ready, 1'b0);
      @(negedge CLK);
      chk({name, "_idle_ready"}, tx_ready, 1'b1);
      chk({name, "_idle_done"}, tx_done, 1'b0);
      $display("frame %s bits=%04h slots=%0d line=%0d cycles", name, bits, slots, line);
   endtask

   task automatic run_vec(input vec_t v);
      wait_ready(v.name);
      tx_valid    = 1'b1;
      tx_data     = v.data;
      parity_mode = v.mode;
      @(negedge CLK);
      check_frame(v.name, v.bits, v.slots, 1, ~v.data, 1'b0, ~v.mode);
   endtask

   initial begin
      logic [7:0] seen2;
      logic       flag;
      checks      = 0;
      errors      = 0;
      RST_n       = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = '0;
      parity_mode = '0;
      v2          = 1'b0;
      d2          = '0;
      m2          = '0;

      vecs[0] = '{"d55_m0", 8'h55, 2'b00, 10, 16'h02AA};
      vecs[1] = '{"d07_even", 8'h07, 2'b01, PAR ? 11 : 10, PAR ? 16'h060E : 16'h020E};
      vecs[2] = '{"d07_odd", 8'h07, 2'b10, PAR ? 11 : 10, PAR ? 16'h040E : 16'h020E};
      vecs[3] = '{"dFF_m3", 8'hFF, 2'b11, 10, 16'h03FE};
      vecs[4] = '{"d00_odd", 8'h00, 2'b10, PAR ? 11 : 10, PAR ? 16'h0600 : 16'h0200};

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_pin", tx_pin, 1'b1);
      chk("rst_ready", tx_ready, 1'b0);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      chk("rst_pin2", pin2, 1'b1);
      chk("rst_ready2", rdy2, 1'b0);
      RST_n = 1'b1;
      #1;
      chk("rel_ready_before_edge", tx_ready, 1'b0);
      @(negedge CLK);
      chk("rel_ready_after_edge", tx_ready, 1'b1);
      chk("rel_ready2_after_edge", rdy2, 1'b1);
      $display("reset released");

      // Table-driven frames
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Tx_Valid held high: back-to-back frames 42 cycles apart, data changed mid-frame
      wait_ready("hold");
      tx_valid    = 1'b1;
      tx_data     = 8'hA3;
      parity_mode = 2'b00;
      @(negedge CLK);
      check_frame("hold_A3", 16'h0346, 10, 20, 8'h3C, 1'b1, 2'b00);
      @(negedge CLK);
      check_frame("hold_3C", 16'h0278, 10, 20, 8'hA3, 1'b0, 2'b00);

      // Second instance: DATA_W=5, STOP_BITS=2, data 0x1F -> 32 line cycles
      chk("w5_ready", rdy2, 1'b1);
      v2 = 1'b1;
      d2 = 5'h1F;
      m2 = 2'b00;
      @(negedge CLK);
      v2    = 1'b0;
      d2    = 5'h00;
      seen2 = '0;
      flag  = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         if (c > 1) @(negedge CLK);
         if (((c - 1) % CPB) == 0 || pin2 !== (c > CPB)) seen2[(c - 1) / CPB] = pin2;
         flag = flag | done2;
      end
      chk("w5_slots", seen2, 8'hFE);
      chk("w5_done_early", flag, 1'b0);
      @(negedge CLK);
      chk("w5_done_pulse", done2, 1'b1);
      chk("w5_done_pin", pin2, 1'b1);
      chk("w5_done_busy", busy2, 1'b0);
      @(negedge CLK);
      chk("w5_idle_ready", rdy2, 1'b1);
      $display("frame w5s2 data=1f line=32 cycles");

      // Reset during data bit 3 (line cycles 17..20), data 0x00 keeps line low there
      wait_ready("midrst");
      tx_valid    = 1'b1;
      tx_data     = 8'h00;
      parity_mode = 2'b00;
      @(negedge CLK);
      tx_valid = 1'b0;
      repeat (17) @(negedge CLK);
      chk("midrst_pin_low", tx_pin, 1'b0);
      RST_n = 1'b0;
      #1;
      chk("midrst_pin_async", tx_pin, 1'b1);
      chk("midrst_busy", tx_busy, 1'b0);
      chk("midrst_ready", tx_ready, 1'b0);
      flag = tx_done;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         flag = flag | tx_done;
      end
      RST_n = 1'b1;
      #1;
      chk("midrst_no_done", flag | tx_done, 1'b0);
      chk("midrst_ready_before_edge", tx_ready, 1'b0);
      @(negedge CLK);
      chk("midrst_ready_after_edge", tx_ready, 1'b1);
      chk("midrst_pin_idle", tx_pin, 1'b1);
      $display("mid-frame reset applied and released");
      vecs[0].name = "post_reset_d55";
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
